// File: rtl/cam_pkg.sv
// Shared types for the camera capture path: sequencer state encoding and pixel word width.
package cam_pkg;

  localparam int unsigned PixW = 16;  // RGB565 word

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StWaitSof,
    StCapture,
    StDone
  } cam_state_e;

endpackage

// File: rtl/cam_byte_pack.sv
// Pairs href-qualified camera bytes (high byte first) into 16-bit words with a one-cycle write pulse.
module cam_byte_pack
  import cam_pkg::*;
(
  input  logic            PCLK,
  input  logic            HRESETn,
  input  logic            en,
  input  logic            href,
  input  logic [7:0]      data,
  output logic            we,
  output logic [PixW-1:0] wdata
);

  logic       toggle_q;
  logic [7:0] hi_q;

  always_ff @(posedge PCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      toggle_q <= 1'b0;
      hi_q     <= '0;
      we       <= 1'b0;
      wdata    <= '0;
    end else begin
      we <= 1'b0;
      if (en && href) begin
        toggle_q <= ~toggle_q;
        if (!toggle_q) begin
          hi_q <= data;
        end else begin
          we    <= 1'b1;
          wdata <= {hi_q, data};
        end
      end else begin
        // A high byte left waiting when href drops is simply forgotten.
        toggle_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cam_capture_sequencer.sv
// Camera capture sequencer: frame arming, ping-pong bank ownership, write addressing and status.
// Optional crop window enabled by defining CAM_CROP_EN.
module cam_capture_sequencer
  import cam_pkg::*;
#(
  parameter int unsigned AW    = 16,
  parameter int unsigned DEPTH = 65536
) (
  input  logic            PCLK,
  input  logic            HRESETn,
  input  logic            cap_en,
  input  logic            cap_cont,
  input  logic [1:0]      bank_release,
  input  logic            cam_vsync,
  input  logic            cam_href,
  input  logic [7:0]      cam_data,
`ifdef CAM_CROP_EN
  input  logic [10:0]     crop_x0,
  input  logic [10:0]     crop_w,
  input  logic [9:0]      crop_y0,
  input  logic [9:0]      crop_h,
`endif
  output logic            ram_we,
  output logic [AW:0]     ram_addr,
  output logic [PixW-1:0] ram_wdata,
  output logic [1:0]      bank_full,
  output logic            frame_done,
  output logic [AW:0]     frame_words,
  output logic            ovf_err,
  output logic [7:0]      skip_cnt
);

  localparam logic [AW:0] DepthW = DEPTH[AW:0];

  cam_state_e  state_q;
  logic        wr_bank_q;
  logic [AW:0] word_addr_q;
  logic [1:0]  bank_full_q;
  logic        frame_done_q;
  logic [AW:0] frame_words_q;
  logic        ovf_q;
  logic [7:0]  skip_q;
  logic        vsync_q;

  logic        pack_we;
  logic        in_win;
  logic        wr_ok;
  logic        vsync_fall;
  logic        vsync_rise;
  logic        bank_avail;
  logic        bank_pick;

  cam_byte_pack u_pack (
    .PCLK    (PCLK),
    .HRESETn (HRESETn),
    .en      (state_q == StCapture),
    .href    (cam_href),
    .data    (cam_data),
    .we      (pack_we),
    .wdata   (ram_wdata)
  );

`ifdef CAM_CROP_EN
  logic        href_q;
  logic [9:0]  line_q;
  logic [10:0] px_q;

  always_ff @(posedge PCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      href_q <= 1'b0;
      line_q <= '0;
      px_q   <= '0;
    end else begin
      href_q <= cam_href;
      if (state_q != StCapture) begin
        line_q <= '0;
        px_q   <= '0;
      end else if (cam_href && !href_q) begin
        line_q <= line_q + 10'd1;
        px_q   <= '0;
      end else if (pack_we) begin
        px_q <= px_q + 11'd1;
      end
    end
  end

  // line_q already counts the current line, so line index = line_q - 1.
  assign in_win = ({1'b0, line_q} > {1'b0, crop_y0}) &&
                  ({1'b0, line_q} <= ({1'b0, crop_y0} + {1'b0, crop_h})) &&
                  ({1'b0, px_q} >= {1'b0, crop_x0}) &&
                  ({1'b0, px_q} < ({1'b0, crop_x0} + {1'b0, crop_w}));
`else
  assign in_win = 1'b1;
`endif

  assign wr_ok      = pack_we && (state_q == StCapture) && in_win;
  assign ram_we     = wr_ok && (word_addr_q != DepthW);
  assign ram_addr   = {wr_bank_q, word_addr_q[AW-1:0]};
  assign vsync_fall = vsync_q && !cam_vsync;
  assign vsync_rise = !vsync_q && cam_vsync;
  assign bank_avail = (bank_full_q != 2'b11);
  assign bank_pick  = (bank_full_q == 2'b01);  // only bank 1 free

  always_ff @(posedge PCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q       <= StIdle;
      wr_bank_q     <= 1'b0;
      word_addr_q   <= '0;
      bank_full_q   <= '0;
      frame_done_q  <= 1'b0;
      frame_words_q <= '0;
      ovf_q         <= 1'b0;
      skip_q        <= '0;
      vsync_q       <= 1'b0;
    end else begin
      vsync_q      <= cam_vsync;
      frame_done_q <= 1'b0;
      bank_full_q  <= bank_full_q & ~bank_release;
      if (ram_we) word_addr_q <= word_addr_q + 1'b1;
      if (wr_ok && (word_addr_q == DepthW)) ovf_q <= 1'b1;
      if (!cap_en) begin
        state_q <= StIdle;
        ovf_q   <= 1'b0;
        skip_q  <= '0;
      end else begin
        unique case (state_q)
          StIdle: state_q <= StArm;
          StArm: begin
            if (bank_avail) begin
              wr_bank_q   <= bank_pick;
              word_addr_q <= '0;
              state_q     <= StWaitSof;
            end else if (vsync_fall && (skip_q != 8'hFF)) begin
              skip_q <= skip_q + 8'd1;
            end
          end
          StWaitSof: if (vsync_fall) state_q <= StCapture;
          StCapture: if (vsync_rise) state_q <= StDone;
          StDone: begin
            // Later bit assignment overrides a same-cycle release of this bank.
            bank_full_q[wr_bank_q] <= 1'b1;
            frame_done_q           <= 1'b1;
            frame_words_q          <= word_addr_q;
            state_q                <= cap_cont ? StArm : StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bank_full   = bank_full_q;
  assign frame_done  = frame_done_q;
  assign frame_words = frame_words_q;
  assign ovf_err     = ovf_q;
  assign skip_cnt    = skip_q;

endmodule
